// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types and constants for the 3x3 convolution sequencer.
//             Sequencer state encoding, memory bank enable codes, output-bank
//             mode codes and the matrix dimensions.
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

  // Sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_F = 3'd2,
    RD     = 3'd3,
    ACC    = 3'd4,
    WR     = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Memory bank enable codes
  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_RD   = 2'b10;
  localparam logic [1:0] EN_WR   = 2'b11;

  // Output bank selection; 2'b11 aliases to the S bank
  localparam logic [1:0] MODE_S     = 2'b00;
  localparam logic [1:0] MODE_P1    = 2'b01;
  localparam logic [1:0] MODE_P2    = 2'b10;
  localparam logic [1:0] MODE_S_ALT = 2'b11;

  // Matrix geometry
  localparam int IN_DIM    = 4;
  localparam int F_DIM     = 3;
  localparam int OUT_DIM   = 2;
  localparam int IN_BYTES  = IN_DIM * IN_DIM;
  localparam int F_BYTES   = F_DIM * F_DIM;
  localparam int OUT_COUNT = OUT_DIM * OUT_DIM;

endpackage
`default_nettype wire

// File: rtl/conv_mac3.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac3
//  Purpose  : Combinational 3-term unsigned dot product,
//             o_sum = a0*f0 + a1*f1 + a2*f2, zero-extended to ACCW bits.
//  Ports    : i_a0..i_a2  DW-bit input-row operands
//             i_f0..i_f2  DW-bit filter-row operands
//             o_sum       ACCW-bit sum of the three products
//  Revision : 1.0  initial release
// ============================================================================
module conv_mac3 #(
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic [DW-1:0]   i_a0,
  input  logic [DW-1:0]   i_a1,
  input  logic [DW-1:0]   i_a2,
  input  logic [DW-1:0]   i_f0,
  input  logic [DW-1:0]   i_f1,
  input  logic [DW-1:0]   i_f2,
  output logic [ACCW-1:0] o_sum
);

  logic [2*DW-1:0] w_p0;
  logic [2*DW-1:0] w_p1;
  logic [2*DW-1:0] w_p2;

  assign w_p0  = i_a0 * i_f0;
  assign w_p1  = i_a1 * i_f1;
  assign w_p2  = i_a2 * i_f2;
  assign o_sum = ACCW'(w_p0) + ACCW'(w_p1) + ACCW'(w_p2);

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_seq_ctrl
//  Purpose  : Sequencer driving memory_module through one 3x3 convolution of
//             a 4x4 input (stride 1, no padding) into a 2x2 result bank.
//  Ports    : clk, rst           clock / synchronous active-high reset
//             start, mode        job launch pulse and output-bank select
//             in_valid, in_data  byte stream (16 input then 9 filter bytes)
//             in_ready           stream byte accepted this cycle
//             busy, done, sat    job status; sat is sticky per job
//             mem_*              address / enable / data_w pins of the memory
//             mem_out_*          registered read data from the memory
//  Revision : 1.0  initial release
// ============================================================================
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          sat,
  output logic [DW-1:0] mem_data_w,
  output logic [3:0]    mem_addr_a0,
  output logic [3:0]    mem_addr_a1,
  output logic [3:0]    mem_addr_a2,
  output logic [3:0]    mem_addr_f0,
  output logic [3:0]    mem_addr_f1,
  output logic [3:0]    mem_addr_f2,
  output logic [1:0]    mem_addr_o,
  output logic [1:0]    mem_en_inp,
  output logic [1:0]    mem_en_fil,
  output logic [1:0]    mem_en_s,
  output logic [1:0]    mem_en_p1,
  output logic [1:0]    mem_en_p2,
  input  logic [DW-1:0] mem_out_a0,
  input  logic [DW-1:0] mem_out_a1,
  input  logic [DW-1:0] mem_out_a2,
  input  logic [DW-1:0] mem_out_f0,
  input  logic [DW-1:0] mem_out_f1,
  input  logic [DW-1:0] mem_out_f2
);

  localparam logic [4:0]      c_A_LAST  = 5'(IN_BYTES - 1);
  localparam logic [4:0]      c_F_LAST  = 5'(F_BYTES - 1);
  localparam logic [ACCW-1:0] c_SAT_MAX = ACCW'((2 ** DW) - 1);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_mode;
  logic [4:0]      r_cnt;
  logic [1:0]      r_pos;
  logic [1:0]      r_row;
  logic [ACCW-1:0] r_acc;
  logic            r_sat;

  logic [ACCW-1:0] w_mac_sum;
  logic [3:0]      w_a_base;
  logic [3:0]      w_f_base;
  logic            w_over;
  logic [DW-1:0]   w_clip;

  // pos -> (oy, ox) = (pos[1], pos[0]); input row base = (oy+row)*4 + ox
  assign w_a_base = (({3'b000, r_pos[1]} + {2'b00, r_row}) << 2) + {3'b000, r_pos[0]};
  // filter row base = row*3
  assign w_f_base = ({2'b00, r_row} << 1) + {2'b00, r_row};

  assign w_over = (r_acc > c_SAT_MAX);
  assign w_clip = w_over ? {DW{1'b1}} : r_acc[DW-1:0];

  conv_mac3 #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .i_a0  (mem_out_a0),
    .i_a1  (mem_out_a1),
    .i_a2  (mem_out_a2),
    .i_f0  (mem_out_f0),
    .i_f1  (mem_out_f1),
    .i_f2  (mem_out_f2),
    .o_sum (w_mac_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD_A;
      LOAD_A:  if (in_valid && (r_cnt == c_A_LAST)) w_next = LOAD_F;
      LOAD_F:  if (in_valid && (r_cnt == c_F_LAST)) w_next = RD;
      RD:      w_next = ACC;
      ACC:     w_next = (r_row < 2'd2) ? RD : WR;
      WR:      w_next = (r_pos < 2'd3) ? RD : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counters, accumulator and job status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_S;
      r_cnt  <= '0;
      r_pos  <= '0;
      r_row  <= '0;
      r_acc  <= '0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_sat  <= 1'b0;
            r_cnt  <= '0;
            r_pos  <= '0;
            r_row  <= '0;
            r_acc  <= '0;
          end
        end
        LOAD_A: begin
          if (in_valid) r_cnt <= (r_cnt == c_A_LAST) ? 5'd0 : r_cnt + 5'd1;
        end
        LOAD_F: begin
          if (in_valid) begin
            if (r_cnt == c_F_LAST) begin
              r_cnt <= '0;
              r_pos <= '0;
              r_row <= '0;
              r_acc <= '0;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        ACC: begin
          r_acc <= r_acc + w_mac_sum;
          if (r_row < 2'd2) r_row <= r_row + 2'd1;
        end
        WR: begin
          r_acc <= '0;
          r_row <= '0;
          if (w_over) r_sat <= 1'b1;
          if (r_pos < 2'd3) r_pos <= r_pos + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode; every pin defaults to zero so idle cycles are deterministic
  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_data_w  = '0;
    mem_addr_a0 = '0;
    mem_addr_a1 = '0;
    mem_addr_a2 = '0;
    mem_addr_f0 = '0;
    mem_addr_f1 = '0;
    mem_addr_f2 = '0;
    mem_addr_o  = '0;
    mem_en_inp  = EN_IDLE;
    mem_en_fil  = EN_IDLE;
    mem_en_s    = EN_IDLE;
    mem_en_p1   = EN_IDLE;
    mem_en_p2   = EN_IDLE;
    case (r_state)
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          mem_en_inp  = EN_WR;
          mem_addr_a0 = r_cnt[3:0];
          mem_data_w  = in_data;
        end
      end
      LOAD_F: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          mem_en_fil  = EN_WR;
          mem_addr_f0 = r_cnt[3:0];
          mem_data_w  = in_data;
        end
      end
      RD: begin
        busy        = 1'b1;
        mem_en_inp  = EN_RD;
        mem_en_fil  = EN_RD;
        mem_addr_a0 = w_a_base;
        mem_addr_a1 = w_a_base + 4'd1;
        mem_addr_a2 = w_a_base + 4'd2;
        mem_addr_f0 = w_f_base;
        mem_addr_f1 = w_f_base + 4'd1;
        mem_addr_f2 = w_f_base + 4'd2;
      end
      ACC: busy = 1'b1;
      WR: begin
        busy       = 1'b1;
        mem_addr_o = r_pos;
        mem_data_w = w_clip;
        case (r_mode)
          MODE_P1: mem_en_p1 = EN_WR;
          MODE_P2: mem_en_p2 = EN_WR;
          default: mem_en_s  = EN_WR;
        endcase
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign sat = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_seq_ctrl
//  Purpose  : Self-checking bench for conv_seq_ctrl with a behavioural model
//             of memory_module, a write scoreboard and a table of jobs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready, busy, done, sat;
  logic [7:0] mem_data_w;
  logic [3:0] mem_addr_a0, mem_addr_a1, mem_addr_a2;
  logic [3:0] mem_addr_f0, mem_addr_f1, mem_addr_f2;
  logic [1:0] mem_addr_o;
  logic [1:0] mem_en_inp, mem_en_fil, mem_en_s, mem_en_p1, mem_en_p2;
  logic [7:0] mem_out_a0 = 8'h00, mem_out_a1 = 8'h00, mem_out_a2 = 8'h00;
  logic [7:0] mem_out_f0 = 8'h00, mem_out_f1 = 8'h00, mem_out_f2 = 8'h00;

  conv_seq_ctrl #(.DW(8), .ACCW(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .sat        (sat),
    .mem_data_w (mem_data_w),
    .mem_addr_a0(mem_addr_a0),
    .mem_addr_a1(mem_addr_a1),
    .mem_addr_a2(mem_addr_a2),
    .mem_addr_f0(mem_addr_f0),
    .mem_addr_f1(mem_addr_f1),
    .mem_addr_f2(mem_addr_f2),
    .mem_addr_o (mem_addr_o),
    .mem_en_inp (mem_en_inp),
    .mem_en_fil (mem_en_fil),
    .mem_en_s   (mem_en_s),
    .mem_en_p1  (mem_en_p1),
    .mem_en_p2  (mem_en_p2),
    .mem_out_a0 (mem_out_a0),
    .mem_out_a1 (mem_out_a1),
    .mem_out_a2 (mem_out_a2),
    .mem_out_f0 (mem_out_f0),
    .mem_out_f1 (mem_out_f1),
    .mem_out_f2 (mem_out_f2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory_module: write on 11, registered read on 10
  logic [7:0] m_inp [16];
  logic [7:0] m_fil [16];
  always @(posedge clk) begin
    if (mem_en_inp == 2'b11) m_inp[mem_addr_a0] <= mem_data_w;
    if (mem_en_inp == 2'b10) begin
      mem_out_a0 <= m_inp[mem_addr_a0];
      mem_out_a1 <= m_inp[mem_addr_a1];
      mem_out_a2 <= m_inp[mem_addr_a2];
    end
    if (mem_en_fil == 2'b11) m_fil[mem_addr_f0] <= mem_data_w;
    if (mem_en_fil == 2'b10) begin
      mem_out_f0 <= m_fil[mem_addr_f0];
      mem_out_f1 <= m_fil[mem_addr_f1];
      mem_out_f2 <= m_fil[mem_addr_f2];
    end
  end

  typedef struct packed {
    logic [1:0]   mode;
    logic [127:0] a;
    logic [71:0]  f;
    logic [31:0]  exp;
    logic         exp_sat;
    logic         stall;
    logic         mid_start;
  } vec_t;

  typedef struct packed {
    logic [1:0] bank;
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  sbq[$];
  vec_t vecs[4];
  int   errors = 0;
  int   checks = 0;
  int   lda_exp = 0;
  int   ldf_exp = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] bank_of(input logic [1:0] m);
    if (m == 2'b01) return 2'd1;
    if (m == 2'b10) return 2'd2;
    return 2'd0;
  endfunction

  // Watches every write on the memory pins, shortly after each falling edge
  task automatic monitor();
    int   n_wr;
    int   n_out;
    wr_t  e;
    logic [1:0] got_bank;
    forever begin
      @(negedge clk);
      #2;
      n_out = int'(mem_en_s == 2'b11) + int'(mem_en_p1 == 2'b11) + int'(mem_en_p2 == 2'b11);
      n_wr  = n_out + int'(mem_en_inp == 2'b11) + int'(mem_en_fil == 2'b11);
      if (mem_en_inp == 2'b11) begin
        chk("a_wr_valid", 64'(in_valid), 64'd1);
        chk("a_wr_addr", 64'(mem_addr_a0), 64'(lda_exp));
        chk("a_wr_data", 64'(mem_data_w), 64'(in_data));
        lda_exp++;
      end
      if (mem_en_fil == 2'b11) begin
        chk("f_wr_valid", 64'(in_valid), 64'd1);
        chk("f_wr_addr", 64'(mem_addr_f0), 64'(ldf_exp));
        chk("f_wr_data", 64'(mem_data_w), 64'(in_data));
        ldf_exp++;
      end
      if (n_wr > 1) chk("single_wr_en", 64'(n_wr), 64'd1);
      if (n_out > 0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_wr", 64'(n_out), 64'd0);
        end else begin
          e = sbq.pop_front();
          got_bank = (mem_en_p1 == 2'b11) ? 2'd1 : (mem_en_p2 == 2'b11) ? 2'd2 : 2'd0;
          chk("out_bank", 64'(got_bank), 64'(e.bank));
          chk("out_addr", 64'(mem_addr_o), 64'(e.addr));
          chk("out_data", 64'(mem_data_w), 64'(e.data));
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    last_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode    = m;
    start   = 1'b1;
    lda_exp = 0;
    ldf_exp = 0;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic run_job(input vec_t v);
    int n;
    for (int p = 0; p < 4; p++)
      sbq.push_back('{bank: bank_of(v.mode), addr: 2'(p), data: v.exp[p*8 +: 8]});
    pulse_start(v.mode);
    chk("sat_clear_at_start", 64'(sat), 64'd0);
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 16; i++) begin
      if (v.stall && i == 8) repeat (3) @(negedge clk);
      send_byte(v.a[i*8 +: 8]);
    end
    for (int i = 0; i < 9; i++) send_byte(v.f[i*8 +: 8]);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (v.mid_start) start = (n == 10);
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("done_latency", 64'(cyc - last_acc), 64'd29);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("sat_at_done", 64'(sat), 64'(v.exp_sat));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    if (v.exp_sat) begin
      repeat (5) @(negedge clk);
      chk("sat_sticky", 64'(sat), 64'd1);
    end
  endtask

  initial begin
    // Job table: A row-major, F row-major, expected results byte p = S/P[p]
    vecs[0] = '0;
    for (int i = 0; i < 16; i++) vecs[0].a[i*8 +: 8] = 8'(i);
    vecs[0].f[4*8 +: 8] = 8'd1;
    vecs[0].exp  = {8'd10, 8'd9, 8'd6, 8'd5};
    vecs[0].mode = 2'b00;

    vecs[1] = '0;
    vecs[1].a = {16{8'd1}};
    vecs[1].f = {9{8'd1}};
    vecs[1].exp = {4{8'd9}};
    vecs[1].mode = 2'b01;
    vecs[1].mid_start = 1'b1;

    vecs[2] = '0;
    for (int i = 0; i < 16; i++) vecs[2].a[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 9; i++) vecs[2].f[i*8 +: 8] = 8'(i + 1);
    vecs[2].exp = {4{8'd255}};  // raw sums 303, 348, 483, 528
    vecs[2].exp_sat = 1'b1;
    vecs[2].mode = 2'b10;

    vecs[3] = '0;
    for (int i = 0; i < 16; i++) vecs[3].a[i*8 +: 8] = 8'(i);
    vecs[3].f[0*8 +: 8] = 8'd1;
    vecs[3].f[8*8 +: 8] = 8'd1;
    vecs[3].exp = {8'd20, 8'd18, 8'd12, 8'd10};  // A[p0] + A[p0+10]
    vecs[3].mode = 2'b11;
    vecs[3].stall = 1'b1;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_status", 64'({mem_en_inp, mem_en_fil, mem_en_s, mem_en_p1, mem_en_p2,
                             in_ready, busy, done, sat, mem_data_w}), 64'd0);
    chk("reset_addrs", 64'({mem_addr_a0, mem_addr_a1, mem_addr_a2, mem_addr_f0,
                            mem_addr_f1, mem_addr_f2, mem_addr_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Abort a job after 4 filter bytes
    pulse_start(2'b00);
    for (int i = 0; i < 16; i++) send_byte(8'(i + 100));
    for (int i = 0; i < 4; i++) send_byte(8'(i + 200));
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_enables", 64'({mem_en_inp, mem_en_fil, mem_en_s, mem_en_p1, mem_en_p2}), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 4; j++) run_job(vecs[j]);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
